// File: rtl/rack_jtag_tap_if.sv
// JTAG pin bundle plus the USER register parallel capture/update interface.
// The master drives the pins and capture data; the TAP is the slave.
interface rack_jtag_tap_if #(
  parameter int USER_LEN = 32
);
  logic                TCK;
  logic                TMS;
  logic                TDI;
  logic                TDO;
  logic                TDO_OE;
  logic [USER_LEN-1:0] user_capture_data_i;
  logic                user_capture_o;
  logic [USER_LEN-1:0] user_update_data_o;
  logic                user_update_o;

  modport master (
    output TCK, TMS, TDI, user_capture_data_i,
    input  TDO, TDO_OE, user_capture_o, user_update_data_o, user_update_o
  );

  modport slave (
    input  TCK, TMS, TDI, user_capture_data_i,
    output TDO, TDO_OE, user_capture_o, user_update_data_o, user_update_o
  );
endinterface

// File: rtl/rack_jtag_tap.sv
// IEEE 1149.1 TAP responder with TCK/TMS/TDI oversampled in wb_clk.
// Provides IR, BYPASS, IDCODE and a USER DR with parallel capture/update.
//
// state    | enc | meaning
// TLR      |  F  | test-logic-reset, IR forced to IDCODE_INSTR
// RTI      |  C  | run-test/idle
// SEL_DR   |  7  | select DR scan
// CAP_DR   |  6  | load selected DR on next rise
// SH_DR    |  2  | shift selected DR, TDO driven
// EX1_DR   |  1  | exit1 DR
// PAUSE_DR |  3  | pause DR
// EX2_DR   |  0  | exit2 DR
// UPD_DR   |  5  | USER DR published to fabric
// SEL_IR   |  4  | select IR scan
// CAP_IR   |  E  | load IR capture pattern on next rise
// SH_IR    |  A  | shift IR, TDO driven
// EX1_IR   |  9  | exit1 IR
// PAUSE_IR |  B  | pause IR
// EX2_IR   |  8  | exit2 IR
// UPD_IR   |  D  | IR shift register becomes current instruction
module rack_jtag_tap #(
  parameter int                 IR_LEN       = 4,
  parameter int                 USER_LEN     = 32,
  parameter logic [31:0]        IDCODE       = 32'h1A5B_C093,
  parameter logic [IR_LEN-1:0]  IDCODE_INSTR = IR_LEN'(1),
  parameter logic [IR_LEN-1:0]  USER_INSTR   = IR_LEN'(2)
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  rack_jtag_tap_if.slave    jtag,
  output logic [IR_LEN-1:0] ir_o,
  output logic [3:0]        tap_state_o
);

  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_e;

  tap_state_e state_q, state_d;

  logic tck_meta_q, tck_sync_q, tck_prev_q;
  logic tms_meta_q, tms_sync_q;
  logic tdi_meta_q, tdi_sync_q;
  logic tck_rise, tck_fall;

  logic [IR_LEN-1:0]   ir_q, ir_d;
  logic [IR_LEN-1:0]   ir_shift_q, ir_shift_d, ir_shifted, ir_capture;
  logic                ir_upd_pend_q, ir_upd_pend_d;
  logic                bypass_q, bypass_d;
  logic [31:0]         idcode_q, idcode_d, idcode_shifted;
  logic [USER_LEN-1:0] user_shift_q, user_shift_d, user_shifted;
  logic [USER_LEN-1:0] user_data_q, user_data_d;
  logic                user_capture_q, user_capture_d;
  logic                user_update_q, user_update_d;
  logic                tdo_q, tdo_d;
  logic                tdo_oe_q, tdo_oe_d;
  logic                sel_idcode, sel_user, dr_lsb;

  assign tck_rise   = tck_sync_q & ~tck_prev_q;
  assign tck_fall   = ~tck_sync_q & tck_prev_q;
  assign sel_idcode = (ir_q == IDCODE_INSTR);
  assign sel_user   = (ir_q == USER_INSTR);

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      case (state_q)
        TLR:      state_d = tms_sync_q ? TLR      : RTI;
        RTI:      state_d = tms_sync_q ? SEL_DR   : RTI;
        SEL_DR:   state_d = tms_sync_q ? SEL_IR   : CAP_DR;
        CAP_DR:   state_d = tms_sync_q ? EX1_DR   : SH_DR;
        SH_DR:    state_d = tms_sync_q ? EX1_DR   : SH_DR;
        EX1_DR:   state_d = tms_sync_q ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state_d = tms_sync_q ? EX2_DR   : PAUSE_DR;
        EX2_DR:   state_d = tms_sync_q ? UPD_DR   : SH_DR;
        UPD_DR:   state_d = tms_sync_q ? SEL_DR   : RTI;
        SEL_IR:   state_d = tms_sync_q ? TLR      : CAP_IR;
        CAP_IR:   state_d = tms_sync_q ? EX1_IR   : SH_IR;
        SH_IR:    state_d = tms_sync_q ? EX1_IR   : SH_IR;
        EX1_IR:   state_d = tms_sync_q ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state_d = tms_sync_q ? EX2_IR   : PAUSE_IR;
        EX2_IR:   state_d = tms_sync_q ? UPD_IR   : SH_IR;
        UPD_IR:   state_d = tms_sync_q ? SEL_DR   : RTI;
        default:  state_d = TLR;
      endcase
    end
  end

  always_comb begin
    ir_shifted                   = ir_shift_q >> 1;
    ir_shifted[IR_LEN-1]         = tdi_sync_q;
    idcode_shifted               = idcode_q >> 1;
    idcode_shifted[31]           = tdi_sync_q;
    user_shifted                 = user_shift_q >> 1;
    user_shifted[USER_LEN-1]     = tdi_sync_q;
    ir_capture                   = '0;
    ir_capture[0]                = 1'b1;

    if (sel_idcode) begin
      dr_lsb = idcode_q[0];
    end else if (sel_user) begin
      dr_lsb = user_shift_q[0];
    end else begin
      dr_lsb = bypass_q;
    end
  end

  always_comb begin
    ir_d           = ir_q;
    ir_shift_d     = ir_shift_q;
    ir_upd_pend_d  = 1'b0;
    bypass_d       = bypass_q;
    idcode_d       = idcode_q;
    user_shift_d   = user_shift_q;
    user_data_d    = user_data_q;
    user_capture_d = 1'b0;
    user_update_d  = 1'b0;
    tdo_d          = tdo_q;
    tdo_oe_d       = tdo_oe_q;

    if (tck_rise) begin
      case (state_q)
        SH_IR: ir_shift_d = ir_shifted;
        SH_DR: begin
          if (sel_idcode) begin
            idcode_d = idcode_shifted;
          end else if (sel_user) begin
            user_shift_d = user_shifted;
          end else begin
            bypass_d = tdi_sync_q;
          end
        end
        CAP_IR: ir_shift_d = ir_capture;
        CAP_DR: begin
          if (sel_idcode) begin
            idcode_d = IDCODE;
          end else if (sel_user) begin
            user_shift_d   = jtag.user_capture_data_i;
            user_capture_d = 1'b1;
          end else begin
            bypass_d = 1'b0;
          end
        end
        default: ;
      endcase

      if (state_d == UPD_IR) begin
        ir_upd_pend_d = 1'b1;
      end
      // Update-DR is only entered from Exit1/Exit2, so the USER shift register is already final here
      if (state_d == UPD_DR && sel_user) begin
        user_data_d   = user_shift_q;
        user_update_d = 1'b1;
      end
    end

    if (ir_upd_pend_q) begin
      ir_d = ir_shift_q;
    end
    if (state_q == TLR) begin
      ir_d = IDCODE_INSTR;
    end

    if (tck_fall) begin
      if (state_q == SH_IR) begin
        tdo_d    = ir_shift_q[0];
        tdo_oe_d = 1'b1;
      end else if (state_q == SH_DR) begin
        tdo_d    = dr_lsb;
        tdo_oe_d = 1'b1;
      end else begin
        tdo_d    = 1'b0;
        tdo_oe_d = 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      tck_meta_q     <= 1'b0;
      tck_sync_q     <= 1'b0;
      tck_prev_q     <= 1'b0;
      tms_meta_q     <= 1'b0;
      tms_sync_q     <= 1'b0;
      tdi_meta_q     <= 1'b0;
      tdi_sync_q     <= 1'b0;
      ir_q           <= IDCODE_INSTR;
      ir_shift_q     <= '0;
      ir_upd_pend_q  <= 1'b0;
      bypass_q       <= 1'b0;
      idcode_q       <= '0;
      user_shift_q   <= '0;
      user_data_q    <= '0;
      user_capture_q <= 1'b0;
      user_update_q  <= 1'b0;
      tdo_q          <= 1'b0;
      tdo_oe_q       <= 1'b0;
    end else begin
      tck_meta_q     <= jtag.TCK;
      tck_sync_q     <= tck_meta_q;
      tck_prev_q     <= tck_sync_q;
      tms_meta_q     <= jtag.TMS;
      tms_sync_q     <= tms_meta_q;
      tdi_meta_q     <= jtag.TDI;
      tdi_sync_q     <= tdi_meta_q;
      ir_q           <= ir_d;
      ir_shift_q     <= ir_shift_d;
      ir_upd_pend_q  <= ir_upd_pend_d;
      bypass_q       <= bypass_d;
      idcode_q       <= idcode_d;
      user_shift_q   <= user_shift_d;
      user_data_q    <= user_data_d;
      user_capture_q <= user_capture_d;
      user_update_q  <= user_update_d;
      tdo_q          <= tdo_d;
      tdo_oe_q       <= tdo_oe_d;
    end
  end

  assign jtag.TDO                = tdo_q;
  assign jtag.TDO_OE             = tdo_oe_q;
  assign jtag.user_capture_o     = user_capture_q;
  assign jtag.user_update_data_o = user_data_q;
  assign jtag.user_update_o      = user_update_q;
  assign ir_o                    = ir_q;
  assign tap_state_o             = state_q;

endmodule

// File: tb/tb_rack_jtag_tap.sv
// Directed bench for rack_jtag_tap: drives TCK/TMS/TDI slowly relative to
// wb_clk and checks TAP state, IR, TDO stream and USER handshake pulses.
module tb_rack_jtag_tap;
  localparam int IR_LEN   = 4;
  localparam int USER_LEN = 32;
  localparam logic [31:0] IDCODE_VAL = 32'h1A5B_C093;

  logic              wb_clk = 1'b0;
  logic              wb_rst;
  logic [IR_LEN-1:0] ir;
  logic [3:0]        st;

  rack_jtag_tap_if #(.USER_LEN(USER_LEN)) jif();

  rack_jtag_tap #(
    .IR_LEN      (IR_LEN),
    .USER_LEN    (USER_LEN),
    .IDCODE      (IDCODE_VAL),
    .IDCODE_INSTR(4'h1),
    .USER_INSTR  (4'h2)
  ) dut (
    .wb_clk     (wb_clk),
    .wb_rst     (wb_rst),
    .jtag       (jif.slave),
    .ir_o       (ir),
    .tap_state_o(st)
  );

  always #5 wb_clk = ~wb_clk;

  int errors = 0;
  int checks = 0;
  int cap_cnt = 0;
  int upd_cnt = 0;
  int lat = -1;
  int hi_changes = 0;
  int oe_bad = 0;

  always @(negedge wb_clk) begin
    if (jif.user_capture_o === 1'b1) cap_cnt++;
    if (jif.user_update_o === 1'b1) upd_cnt++;
  end

  // One TCK period: setup, 6 wb_clk high, 6 wb_clk low; records TDO latency after the fall.
  task automatic tck(input logic tms, input logic tdi);
    logic tdo0;
    jif.TMS = tms;
    jif.TDI = tdi;
    repeat (2) @(negedge wb_clk);
    jif.TCK = 1'b1;
    tdo0 = jif.TDO;
    for (int i = 0; i < 6; i++) begin
      @(negedge wb_clk);
      if (jif.TDO !== tdo0) hi_changes++;
    end
    jif.TCK = 1'b0;
    tdo0 = jif.TDO;
    lat = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge wb_clk);
      if (lat < 0 && jif.TDO !== tdo0) lat = i;
    end
  endtask

  task automatic to_shift_dr();
    tck(1'b0, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  task automatic to_shift_ir();
    tck(1'b0, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  // Shift n bits LSB-first, leaving the TAP in Exit1; TDO is sampled before each rise.
  task automatic shift(input int n, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = jif.TDO;
      if (jif.TDO_OE !== 1'b1) oe_bad++;
      tck(i == n - 1, din[i]);
    end
  endtask

  task automatic test_reset();
    wb_rst = 1'b1;
    repeat (4) @(negedge wb_clk);
    checks++; if (st !== 4'hF) begin errors++; $display("FAIL reset_state: got %h want f", st); end
    checks++; if (ir !== 4'h1) begin errors++; $display("FAIL reset_ir: got %h want 1", ir); end
    checks++; if ({jif.TDO, jif.TDO_OE} !== 2'b00) begin errors++; $display("FAIL reset_tdo: got %b want 00", {jif.TDO, jif.TDO_OE}); end
    checks++; if ({jif.user_capture_o, jif.user_update_o} !== 2'b00 || jif.user_update_data_o !== 32'h0) begin
      errors++; $display("FAIL reset_user: got cap=%b upd=%b data=%h want 0 0 0", jif.user_capture_o, jif.user_update_o, jif.user_update_data_o);
    end
    wb_rst = 1'b0;
    repeat (2) @(negedge wb_clk);
    to_shift_dr();
    checks++; if (st !== 4'h2) begin errors++; $display("FAIL reach_shift_dr: got %h want 2", st); end
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
    checks++; if (st !== 4'hF) begin errors++; $display("FAIL tms5_state: got %h want f", st); end
    checks++; if (ir !== 4'h1 || jif.TDO_OE !== 1'b0) begin errors++; $display("FAIL tms5_ir_oe: got ir=%h oe=%b want 1 0", ir, jif.TDO_OE); end
  endtask

  task automatic test_idcode();
    logic [63:0] dout;
    tck(1'b0, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    checks++; if (st !== 4'h6 || jif.TDO_OE !== 1'b0) begin errors++; $display("FAIL idc_capture: got st=%h oe=%b want 6 0", st, jif.TDO_OE); end
    hi_changes = 0;
    oe_bad = 0;
    tck(1'b0, 1'b0);
    checks++; if (lat !== 3) begin errors++; $display("FAIL idc_tdo_latency: got %0d want 3", lat); end
    checks++; if (jif.TDO !== 1'b1 || jif.TDO_OE !== 1'b1) begin errors++; $display("FAIL idc_first_bit: got tdo=%b oe=%b want 1 1", jif.TDO, jif.TDO_OE); end
    shift(32, 64'h0, dout);
    checks++; if (dout[31:0] !== IDCODE_VAL) begin errors++; $display("FAIL idc_value: got %h want %h", dout[31:0], IDCODE_VAL); end
    checks++; if (oe_bad !== 0 || jif.TDO_OE !== 1'b0 || st !== 4'h1) begin
      errors++; $display("FAIL idc_oe_window: got oe_bad=%0d oe=%b st=%h want 0 0 1", oe_bad, jif.TDO_OE, st);
    end
    checks++; if (hi_changes !== 0) begin errors++; $display("FAIL idc_tdo_on_rise: got %0d changes while TCK high want 0", hi_changes); end
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  task automatic test_ir_scan();
    logic [63:0] dout;
    to_shift_ir();
    checks++; if (st !== 4'hA) begin errors++; $display("FAIL ir_reach_shift: got %h want a", st); end
    shift(4, 64'hF, dout);
    checks++; if (dout[3:0] !== 4'b0001) begin errors++; $display("FAIL ir_capture_out: got %b want 0001", dout[3:0]); end
    checks++; if (ir !== 4'h1) begin errors++; $display("FAIL ir_before_update: got %h want 1", ir); end
    tck(1'b1, 1'b0);
    checks++; if (ir !== 4'hF || st !== 4'hD) begin errors++; $display("FAIL ir_update: got ir=%h st=%h want f d", ir, st); end
    tck(1'b0, 1'b0);
  endtask

  task automatic test_bypass();
    logic [63:0] dout;
    int u0;
    u0 = upd_cnt;
    to_shift_dr();
    shift(8, 64'hB2, dout);
    checks++; if (dout[7:0] !== 8'h64) begin errors++; $display("FAIL bypass_out: got %h want 64", dout[7:0]); end
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    checks++; if (upd_cnt !== u0) begin errors++; $display("FAIL bypass_no_update: got %0d pulses want 0", upd_cnt - u0); end
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0);
    checks++; if (ir !== 4'h1 || st !== 4'hF) begin errors++; $display("FAIL tlr_ir_restore: got ir=%h st=%h want 1 f", ir, st); end
  endtask

  task automatic test_user();
    logic [63:0] dout;
    int c0, u0;
    jif.user_capture_data_i = 32'hDEAD_BEEF;
    to_shift_ir();
    shift(4, 64'h2, dout);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    checks++; if (ir !== 4'h2) begin errors++; $display("FAIL user_ir: got %h want 2", ir); end
    c0 = cap_cnt;
    u0 = upd_cnt;
    to_shift_dr();
    checks++; if (cap_cnt - c0 !== 1) begin errors++; $display("FAIL user_capture_pulse: got %0d want 1", cap_cnt - c0); end
    shift(32, 64'h0123_4567, dout);
    checks++; if (dout[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL user_tdo: got %h want deadbeef", dout[31:0]); end
    checks++; if (upd_cnt !== u0) begin errors++; $display("FAIL user_early_update: got %0d want 0", upd_cnt - u0); end
    tck(1'b1, 1'b0);
    checks++; if (upd_cnt - u0 !== 1) begin errors++; $display("FAIL user_update_pulse: got %0d want 1", upd_cnt - u0); end
    checks++; if (jif.user_update_data_o !== 32'h0123_4567) begin errors++; $display("FAIL user_update_data: got %h want 01234567", jif.user_update_data_o); end
    tck(1'b0, 1'b0);
    checks++; if (cap_cnt - c0 !== 1) begin errors++; $display("FAIL user_capture_once: got %0d want 1", cap_cnt - c0); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] dout;
    logic [9:0] pat;
    int u0;
    pat = 10'b10_1100_1011;
    u0 = upd_cnt;
    to_shift_dr();
    for (int i = 0; i < 10; i++) tck(1'b0, pat[i]);
    wb_rst = 1'b1;
    repeat (3) @(negedge wb_clk);
    checks++; if (st !== 4'hF || ir !== 4'h1) begin errors++; $display("FAIL mid_reset_state: got st=%h ir=%h want f 1", st, ir); end
    checks++; if (jif.user_update_data_o !== 32'h0 || jif.TDO_OE !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs: got data=%h oe=%b want 0 0", jif.user_update_data_o, jif.TDO_OE);
    end
    wb_rst = 1'b0;
    repeat (3) @(negedge wb_clk);
    checks++; if (upd_cnt !== u0) begin errors++; $display("FAIL mid_reset_no_update: got %0d want 0", upd_cnt - u0); end
    to_shift_dr();
    shift(32, 64'h0, dout);
    checks++; if (dout[31:0] !== IDCODE_VAL) begin errors++; $display("FAIL mid_reset_idcode: got %h want %h", dout[31:0], IDCODE_VAL); end
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
  endtask

  initial begin
    wb_rst = 1'b1;
    jif.TCK = 1'b0;
    jif.TMS = 1'b1;
    jif.TDI = 1'b0;
    jif.user_capture_data_i = '0;
    test_reset();
    test_idcode();
    test_ir_scan();
    test_bypass();
    test_user();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
